// File: rtl/payment_controller.sv
// Exit-lane payment controller: requests the fee, collects coins, then either
// settles (change + gate pulse) or refunds on cancel/timeout.
module payment_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       exit_request,
  input  logic [7:0] vehicle_id_in,
  output logic       calculate_fee,
  input  logic [7:0] fee_amount,
  input  logic       fee_valid,
  input  logic       coin_valid,
  input  logic [7:0] coin_value,
  input  logic       cancel,
  output logic       busy,
  output logic [7:0] amount_due,
  output logic [8:0] amount_paid,
  output logic       change_valid,
  output logic [7:0] change_amount,
  output logic       gate_open,
  output logic [7:0] done_id,
  output logic       refund_valid,
  output logic [8:0] refund_amount,
  output logic       timeout_error
);

  typedef enum logic [2:0] {IDLE, REQUEST, WAIT_FEE, COLLECT, SETTLE, REFUND} state_t;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [TIMER_W-1:0] timer, timer_nxt;
  logic [7:0]         vehicle_id, vehicle_id_nxt;
  logic [7:0]         amount_due_nxt, change_amount_nxt, done_id_nxt;
  logic [8:0]         amount_paid_nxt, refund_amount_nxt;
  logic               calculate_fee_nxt, change_valid_nxt, gate_open_nxt;
  logic               refund_valid_nxt, timeout_error_nxt, busy_nxt;

  logic [8:0]         coin_total;
  logic [TIMER_W-1:0] timer_inc;
  logic               timer_expired;

  assign coin_total    = amount_paid + {1'b0, coin_value};
  assign timer_inc     = timer + TIMER_W'(1);
  assign timer_expired = (timer_inc == TIMER_LAST);

  // Every output is registered, so the next-state logic also computes the
  // next value of each output; pulses fall back to 0 unless set below.
  always_comb begin
    state_nxt         = state;
    timer_nxt         = timer;
    vehicle_id_nxt    = vehicle_id;
    amount_due_nxt    = amount_due;
    amount_paid_nxt   = amount_paid;
    change_amount_nxt = change_amount;
    done_id_nxt       = done_id;
    refund_amount_nxt = refund_amount;
    calculate_fee_nxt = 1'b0;
    change_valid_nxt  = 1'b0;
    gate_open_nxt     = 1'b0;
    refund_valid_nxt  = 1'b0;
    timeout_error_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (exit_request) begin
          vehicle_id_nxt = vehicle_id_in;
          state_nxt      = REQUEST;
        end
      end
      REQUEST: begin
        calculate_fee_nxt = 1'b1;
        timer_nxt         = '0;
        state_nxt         = WAIT_FEE;
      end
      WAIT_FEE: begin
        if (fee_valid) begin
          amount_due_nxt  = fee_amount;
          amount_paid_nxt = '0;
          timer_nxt       = '0;
          state_nxt       = (fee_amount == 8'd0) ? SETTLE : COLLECT;
        end else if (timer_expired) begin
          timeout_error_nxt = 1'b1;
          timer_nxt         = '0;
          state_nxt         = IDLE;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      COLLECT: begin
        // A coin arriving with cancel is always counted before the cancel is honoured.
        if (coin_valid) begin
          amount_paid_nxt = coin_total;
          timer_nxt       = '0;
          if (coin_total >= {1'b0, amount_due}) state_nxt = SETTLE;
          else if (cancel)                      state_nxt = REFUND;
        end else if (cancel) begin
          state_nxt = REFUND;
        end else if (timer_expired) begin
          timeout_error_nxt = 1'b1;
          timer_nxt         = '0;
          state_nxt         = REFUND;
        end else begin
          timer_nxt = timer_inc;
        end
      end
      SETTLE: begin
        change_amount_nxt = 8'(amount_paid - {1'b0, amount_due});
        change_valid_nxt  = 1'b1;
        gate_open_nxt     = 1'b1;
        done_id_nxt       = vehicle_id;
        state_nxt         = IDLE;
      end
      REFUND: begin
        refund_amount_nxt = amount_paid;
        refund_valid_nxt  = (amount_paid != 9'd0);
        state_nxt         = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      vehicle_id    <= '0;
      busy          <= 1'b0;
      amount_due    <= '0;
      amount_paid   <= '0;
      change_amount <= '0;
      done_id       <= '0;
      refund_amount <= '0;
      calculate_fee <= 1'b0;
      change_valid  <= 1'b0;
      gate_open     <= 1'b0;
      refund_valid  <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      state         <= state_nxt;
      timer         <= timer_nxt;
      vehicle_id    <= vehicle_id_nxt;
      busy          <= busy_nxt;
      amount_due    <= amount_due_nxt;
      amount_paid   <= amount_paid_nxt;
      change_amount <= change_amount_nxt;
      done_id       <= done_id_nxt;
      refund_amount <= refund_amount_nxt;
      calculate_fee <= calculate_fee_nxt;
      change_valid  <= change_valid_nxt;
      gate_open     <= gate_open_nxt;
      refund_valid  <= refund_valid_nxt;
      timeout_error <= timeout_error_nxt;
    end
  end

endmodule

// File: doc/payment_controller.md
Name: payment_controller

Overview:
- Exit-side counterpart of the fee calculator: initiates the fee request handshake (drives calculate_fee, consumes fee_amount/fee_valid), then collects coin payment for the vehicle at the exit lane.
- On full payment it issues change and a gate-open pulse; on cancel or timeout it refunds whatever was inserted.
- Sits between the exit sensor/ID reader, the fee calculator and the exit gate actuator.

Parameters:
- TIMEOUT_CYCLES, 1000: idle cycles allowed while waiting for fee_valid or for the next coin; minimum value 2.
- TIMER_W, 16: width of the timeout counter; TIMEOUT_CYCLES must be less than 2^TIMER_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- exit_request  in  1  one-cycle pulse: vehicle at exit, ID on vehicle_id_in
- vehicle_id_in  in  8  ID of the exiting vehicle
- calculate_fee  out  1  one-cycle request pulse to the fee calculator
- fee_amount  in  8  fee from the calculator; sampled only when fee_valid is high
- fee_valid  in  1  one-cycle fee-ready pulse
- coin_valid  in  1  one-cycle pulse: coin inserted
- coin_value  in  8  value of the inserted coin
- cancel  in  1  driver abort request
- busy  out  1  high whenever state is not IDLE
- amount_due  out  8  latched fee for the current vehicle
- amount_paid  out  9  running payment total
- change_valid  out  1  one-cycle pulse; change_amount is valid
- change_amount  out  8  amount paid minus fee
- gate_open  out  1  one-cycle pulse: payment complete
- done_id  out  8  vehicle ID; updated with gate_open
- refund_valid  out  1  one-cycle pulse; refund_amount is valid
- refund_amount  out  9  refunded total
- timeout_error  out  1  one-cycle pulse on timeout

Behaviour:
- Reset:
  - All outputs are 0.
  - State returns to IDLE; the timer and internal latches clear.
  - Reset mid-transaction abandons it with no refund pulse.
- All outputs are registered. Pulse outputs default to 0 each cycle.
- States:
  - IDLE
    - On exit_request: latch vehicle_id_in, go to REQUEST.
    - fee_valid, coin_valid and cancel are ignored.
  - REQUEST (1 cycle)
    - calculate_fee=1 for exactly this cycle.
    - Clear timer, go to WAIT_FEE.
  - WAIT_FEE
    - On fee_valid: latch fee_amount into amount_due, set amount_paid=0, clear timer.
    - If fee_amount==0, go to SETTLE; otherwise go to COLLECT.
    - With no fee_valid, the timer increments each cycle. When the timer reaches TIMEOUT_CYCLES-1: pulse timeout_error, go to IDLE (no refund).
    - coin_valid and cancel are ignored.
  - COLLECT
    - On coin_valid: amount_paid <= amount_paid + coin_value (9-bit), clear timer.
    - If the new total >= amount_due, go to SETTLE.
    - cancel without a completing coin: go to REFUND.
    - If cancel coincides with coin_valid: the coin is always accepted first. If it completes payment, go to SETTLE and drop the cancel. Otherwise go to REFUND, with the coin included in the refund.
    - With no coin, the timer increments. When it reaches TIMEOUT_CYCLES-1: pulse timeout_error in the same cycle as the transition to REFUND.
  - SETTLE (1 cycle)
    - change_amount <= amount_paid - amount_due.
    - Pulse change_valid and gate_open; done_id <= latched ID.
    - Go to IDLE.
  - REFUND (1 cycle)
    - refund_amount <= amount_paid.
    - refund_valid pulses only if amount_paid != 0.
    - Go to IDLE. gate_open stays 0.
- Width rules:
  - The total before the final coin is at most 254 and a coin is at most 255, so amount_paid never exceeds 509 and the 9-bit total never overflows.
  - Change is always less than coin_value, so it fits in 8 bits.
- busy is registered and is 0 only in IDLE. exit_request while busy is dropped, not queued.
- fee_valid outside WAIT_FEE is ignored.
- amount_due, amount_paid, change_amount, refund_amount and done_id hold their values until overwritten by the next transaction.
- Latency, exit_request to calculate_fee: 2 cycles.
  - Cycle after exit_request: state is REQUEST.
  - Following cycle: calculate_fee is visible as a registered output.
- Latency, completing coin to gate_open: 2 cycles (state SETTLE, then registered pulse).

Test Plan:
- Exact payment:
  - Stimulus: exit_request with id 0x2A; calculator returns fee 20; coins 10, 10.
  - Response: calculate_fee pulses once; amount_due=20; gate_open pulses once; change_amount=0; done_id=0x2A; busy returns to 0.
- Overpayment:
  - Stimulus: fee 20; coins 10, 5, 10.
  - Response: amount_paid=25; change_valid pulses with change_amount=5; no refund_valid.
- Cancel with coin in the same cycle:
  - Stimulus: fee 25; coin 10; then cancel together with coin 5.
  - Response: refund_valid pulses with refund_amount=15; gate_open stays 0.
  - Repeat with fee 15: the coincident coin completes payment; gate_open pulses, change 0, no refund.
- Coin timeout (TIMEOUT_CYCLES=8):
  - Stimulus: fee 30; coin 10; then no input.
  - Response: timeout_error and transition to REFUND 7 cycles after the coin cycle; refund_amount=10.
  - Repeat with no coins: timeout_error pulses, no refund_valid.
- Fee timeout and zero fee:
  - Stimulus: no fee_valid after the request.
  - Response: timeout_error, return to IDLE, no gate.
  - Stimulus: fee_amount=0.
  - Response: gate_open with change 0 and no coins required.
- Robustness:
  - Stimulus: exit_request while busy, stray fee_valid/coin_valid in IDLE, and reset asserted during COLLECT.
  - Response: stray inputs ignored; after reset all outputs are 0 and the next transaction runs cleanly.
